multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL expose: clk  in  1  rising-edge clock; all state changes on this edge.
REQ-002 SHALL expose: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL expose: opcode  in  6  IR[31:26], stable from sID onward.
REQ-004 SHALL expose: zero  in  1  ALU zero flag, valid in bEXE.
REQ-005 SHALL expose: PCWre  out  1  PC load enable.
REQ-006 SHALL expose: InsMemRW  out  1  instruction-memory read.
REQ-007 SHALL expose: IRWre  out  1  IR load.
REQ-008 SHALL expose: ExtSel  out  2  00 zero-ext, 01 sign-ext, 10 shamt zero-ext.
REQ-009 SHALL expose: RegOut  out  2  write register select: 00 rt, 01 rd, 10 $31.
REQ-010 SHALL expose: RegWre, ALUSrcB, ALUM2Reg, DataMemRW, WrRegData  out  1 each  reg write, ALU B = immediate, mem-to-reg, mem write, 0 = PC+4 to reg.
REQ-011 SHALL expose: PCSrc  out  2  00 PC+4, 01 branch target, 10 rs (jr), 11 jump target.
REQ-012 SHALL expose: ALUOp  out  3  000 add, 001 sub, 010 slt, 011 or, 100 and, 101 sll.
REQ-013 SHALL expose: state  out  3  current state; halted  out  1  halt latched.

Function
REQ-014 SHALL hold state in a 3-bit register: sIF 000, sID 001, sEXE_LS 010, sMEM 011, sWB_LD 100, bEXE 101, aEXE 110, aWB 111.
REQ-015 SHALL decode outputs combinationally from state, opcode, zero; default all enables 0, selects 00.
REQ-016 sIF SHALL assert InsMemRW=1, IRWre=1, and go to sID, unless halted=1 (then stay in sIF, all outputs 0).
REQ-017 sID SHALL branch: add 000000, sub 000001, or 010000, and 010001, slt 100110, sll 011000, addi 000010, ori 010010 -> aEXE; beq 110100 -> bEXE; sw 110000, lw 110001 -> sEXE_LS; j 111000 -> sIF with PCWre=1, PCSrc=11.
REQ-018 sID with halt 111111 SHALL set halted=1 and go to sIF with PCWre=0.
REQ-019 sID with any undefined opcode SHALL act as NOP: PCWre=1, PCSrc=00, go to sIF.
REQ-020 aEXE SHALL drive ALUOp per opcode (addi->add, ori->or), ALUSrcB=1 and ExtSel=01 for addi, ExtSel=00 for ori, ExtSel=10 for sll; then go to aWB.
REQ-021 aWB SHALL assert RegWre=1, WrRegData=1, RegOut=01 (R-type) or 00 (addi/ori), PCWre=1, PCSrc=00; go to sIF.
REQ-022 bEXE SHALL drive ALUOp=001, ExtSel=01, PCWre=1, PCSrc=01 when zero=1 else 00; go to sIF.
REQ-023 sEXE_LS SHALL drive ALUOp=000, ALUSrcB=1, ExtSel=01; go to sMEM.
REQ-024 sMEM SHALL, for sw, assert DataMemRW=1, PCWre=1 and go to sIF; for lw, go to sWB_LD.
REQ-025 sWB_LD SHALL assert RegWre=1, ALUM2Reg=1, WrRegData=1, RegOut=00, PCWre=1; go to sIF.
REQ-026 Cycle counts SHALL be: ALU 4, beq 3, sw 4, lw 5, j/jal/jr/NOP 2.
REQ-027 PCWre SHALL be asserted in exactly one cycle per instruction, the last.

Reset
REQ-028 rst_n=0 SHALL force state=sIF, halted=0 immediately, independent of clk.
REQ-029 Reset mid-instruction SHALL abort it; no RegWre/DataMemRW/PCWre assertion for the aborted instruction after rst_n falls.
REQ-030 Out of reset, outputs SHALL equal sIF values: InsMemRW=1, IRWre=1, all others 0.

Configuration
REQ-031 Macro CTRL_JAL_JR_EN defined: sID SHALL decode jal 111010 (RegWre=1, RegOut=10, WrRegData=0, PCWre=1, PCSrc=11) and jr 111001 (PCWre=1, PCSrc=10), both -> sIF.
REQ-032 Macro undefined: jal and jr SHALL be treated as undefined opcodes (REQ-019).

Structure
REQ-033 State encodings, opcode constants, ALUOp/ExtSel/RegOut/PCSrc codes SHALL live in shared package multicycle_pkg.
REQ-034 The combinational output decode SHALL be sub-module cu_output_decode; the state and halted registers stay in the top.

Verification
REQ-035 Reset then add (000000) -> states 000,001,110,111,000; RegWre=1, RegOut=01 in 111 only; PCWre=1 only in 111.
REQ-036 beq with zero=1 then zero=0 -> 000,001,101; PCSrc=01 then 00; PCWre=1 in 101 both times.
REQ-037 lw then sw -> lw 000,001,010,011,100 with ALUM2Reg=1 in 100; sw 000,001,010,011 with DataMemRW=1 in 011.
REQ-038 halt (111111) -> halted=1, state parks at 000, all enables 0 for 20 cycles; rst_n pulse clears halted.
REQ-039 rst_n=0 asserted mid-cycle in aWB -> state=000 without clk edge, RegWre drops to 0 same time.
REQ-040 jal with CTRL_JAL_JR_EN -> sID outputs RegOut=10, WrRegData=0, PCSrc=11; without macro -> PCSrc=00, RegWre=0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes and datapath select codes.
package multicycle_pkg;

  typedef enum logic [2:0] {
    StIf    = 3'b000,
    StId    = 3'b001,
    StExeLs = 3'b010,
    StMem   = 3'b011,
    StWbLd  = 3'b100,
    StBExe  = 3'b101,
    StAExe  = 3'b110,
    StAWb   = 3'b111
  } state_t;

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpSub  = 6'b000001;
  localparam logic [5:0] OpAddi = 6'b000010;
  localparam logic [5:0] OpOr   = 6'b010000;
  localparam logic [5:0] OpAnd  = 6'b010001;
  localparam logic [5:0] OpOri  = 6'b010010;
  localparam logic [5:0] OpSll  = 6'b011000;
  localparam logic [5:0] OpSlt  = 6'b100110;
  localparam logic [5:0] OpSw   = 6'b110000;
  localparam logic [5:0] OpLw   = 6'b110001;
  localparam logic [5:0] OpBeq  = 6'b110100;
  localparam logic [5:0] OpJ    = 6'b111000;
  localparam logic [5:0] OpJr   = 6'b111001;
  localparam logic [5:0] OpJal  = 6'b111010;
  localparam logic [5:0] OpHalt = 6'b111111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluSlt = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluAnd = 3'b100;
  localparam logic [2:0] AluSll = 3'b101;

  localparam logic [1:0] ExtZero  = 2'b00;
  localparam logic [1:0] ExtSign  = 2'b01;
  localparam logic [1:0] ExtShamt = 2'b10;

  localparam logic [1:0] RegRt = 2'b00;
  localparam logic [1:0] RegRd = 2'b01;
  localparam logic [1:0] Reg31 = 2'b10;

  localparam logic [1:0] PcNext   = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJr     = 2'b10;
  localparam logic [1:0] PcJump   = 2'b11;

  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpOr) || (op == OpAnd) ||
           (op == OpSlt) || (op == OpSll);
  endfunction

endpackage

// File: rtl/cu_output_decode.sv
// Combinational control decode: datapath controls and next state from state, opcode and zero.
// jal/jr decode is present only when CTRL_JAL_JR_EN is defined.
module cu_output_decode
  import multicycle_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_opcode,
  input  logic        i_zero,
  input  logic        i_halted,
  output state_t      o_next_state,
  output logic        o_set_halt,
  output logic        o_pc_wre,
  output logic        o_ins_mem_rw,
  output logic        o_ir_wre,
  output logic [1:0]  o_ext_sel,
  output logic [1:0]  o_reg_out,
  output logic        o_reg_wre,
  output logic        o_alu_src_b,
  output logic        o_alu_m2reg,
  output logic        o_data_mem_rw,
  output logic        o_wr_reg_data,
  output logic [1:0]  o_pc_src,
  output logic [2:0]  o_alu_op
);

  always_comb begin
    o_next_state  = StIf;
    o_set_halt    = 1'b0;
    o_pc_wre      = 1'b0;
    o_ins_mem_rw  = 1'b0;
    o_ir_wre      = 1'b0;
    o_ext_sel     = ExtZero;
    o_reg_out     = RegRt;
    o_reg_wre     = 1'b0;
    o_alu_src_b   = 1'b0;
    o_alu_m2reg   = 1'b0;
    o_data_mem_rw = 1'b0;
    o_wr_reg_data = 1'b0;
    o_pc_src      = PcNext;
    o_alu_op      = AluAdd;

    unique case (i_state)
      StIf: begin
        if (!i_halted) begin
          o_ins_mem_rw = 1'b1;
          o_ir_wre     = 1'b1;
          o_next_state = StId;
        end
      end
      StId: begin
        case (i_opcode)
          OpAdd, OpSub, OpOr, OpAnd, OpSlt, OpSll, OpAddi, OpOri: o_next_state = StAExe;
          OpBeq:      o_next_state = StBExe;
          OpSw, OpLw: o_next_state = StExeLs;
          OpJ: begin
            o_pc_wre = 1'b1;
            o_pc_src = PcJump;
          end
          OpHalt: o_set_halt = 1'b1;
`ifdef CTRL_JAL_JR_EN
          OpJal: begin
            o_reg_wre = 1'b1;
            o_reg_out = Reg31;
            o_pc_wre  = 1'b1;
            o_pc_src  = PcJump;
          end
          OpJr: begin
            o_pc_wre = 1'b1;
            o_pc_src = PcJr;
          end
`endif
          // Undefined opcodes retire as a NOP.
          default: o_pc_wre = 1'b1;
        endcase
      end
      StAExe: begin
        o_next_state = StAWb;
        case (i_opcode)
          OpSub:  o_alu_op = AluSub;
          OpOr:   o_alu_op = AluOr;
          OpAnd:  o_alu_op = AluAnd;
          OpSlt:  o_alu_op = AluSlt;
          OpSll: begin
            o_alu_op  = AluSll;
            o_ext_sel = ExtShamt;
          end
          OpAddi: begin
            o_alu_src_b = 1'b1;
            o_ext_sel   = ExtSign;
          end
          OpOri: begin
            o_alu_op    = AluOr;
            o_alu_src_b = 1'b1;
          end
          default: o_alu_op = AluAdd;
        endcase
      end
      StAWb: begin
        o_reg_wre     = 1'b1;
        o_wr_reg_data = 1'b1;
        o_reg_out     = is_rtype(i_opcode) ? RegRd : RegRt;
        o_pc_wre      = 1'b1;
      end
      StBExe: begin
        o_alu_op  = AluSub;
        o_ext_sel = ExtSign;
        o_pc_wre  = 1'b1;
        o_pc_src  = i_zero ? PcBranch : PcNext;
      end
      StExeLs: begin
        o_alu_src_b  = 1'b1;
        o_ext_sel    = ExtSign;
        o_next_state = StMem;
      end
      StMem: begin
        if (i_opcode == OpSw) begin
          o_data_mem_rw = 1'b1;
          o_pc_wre      = 1'b1;
        end else if (i_opcode == OpLw) begin
          o_next_state = StWbLd;
        end
      end
      StWbLd: begin
        o_reg_wre     = 1'b1;
        o_alu_m2reg   = 1'b1;
        o_wr_reg_data = 1'b1;
        o_pc_wre      = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control unit: state and halt registers; decode lives in cu_output_decode.
// Optional jal/jr support is enabled by defining CTRL_JAL_JR_EN.
module multicycle_control_unit
  import multicycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  output logic        PCWre,
  output logic        InsMemRW,
  output logic        IRWre,
  output logic [1:0]  ExtSel,
  output logic [1:0]  RegOut,
  output logic        RegWre,
  output logic        ALUSrcB,
  output logic        ALUM2Reg,
  output logic        DataMemRW,
  output logic        WrRegData,
  output logic [1:0]  PCSrc,
  output logic [2:0]  ALUOp,
  output logic [2:0]  state,
  output logic        halted
);

  state_t r_state;
  logic   r_halted;
  state_t w_next_state;
  logic   w_set_halt;

  cu_output_decode u_decode (
    .i_state       (r_state),
    .i_opcode      (opcode),
    .i_zero        (zero),
    .i_halted      (r_halted),
    .o_next_state  (w_next_state),
    .o_set_halt    (w_set_halt),
    .o_pc_wre      (PCWre),
    .o_ins_mem_rw  (InsMemRW),
    .o_ir_wre      (IRWre),
    .o_ext_sel     (ExtSel),
    .o_reg_out     (RegOut),
    .o_reg_wre     (RegWre),
    .o_alu_src_b   (ALUSrcB),
    .o_alu_m2reg   (ALUM2Reg),
    .o_data_mem_rw (DataMemRW),
    .o_wr_reg_data (WrRegData),
    .o_pc_src      (PCSrc),
    .o_alu_op      (ALUOp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIf;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_set_halt) r_halted <= 1'b1;
    end
  end

  assign state  = r_state;
  assign halted = r_halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle vector table plus halt and reset sequences.
module tb_multicycle_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       PCWre, InsMemRW, IRWre, RegWre, ALUSrcB, ALUM2Reg, DataMemRW, WrRegData, halted;
  logic [1:0] ExtSel, RegOut, PCSrc;
  logic [2:0] ALUOp, state;

  multicycle_control_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .zero      (zero),
    .PCWre     (PCWre),
    .InsMemRW  (InsMemRW),
    .IRWre     (IRWre),
    .ExtSel    (ExtSel),
    .RegOut    (RegOut),
    .RegWre    (RegWre),
    .ALUSrcB   (ALUSrcB),
    .ALUM2Reg  (ALUM2Reg),
    .DataMemRW (DataMemRW),
    .WrRegData (WrRegData),
    .PCSrc     (PCSrc),
    .ALUOp     (ALUOp),
    .state     (state),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state,PCWre,InsMemRW,IRWre,ExtSel,RegOut,RegWre,ALUSrcB,ALUM2Reg,DataMemRW,WrRegData,PCSrc,ALUOp,halted}
  logic [20:0] obs;
  assign obs = {state, PCWre, InsMemRW, IRWre, ExtSel, RegOut, RegWre, ALUSrcB, ALUM2Reg,
                DataMemRW, WrRegData, PCSrc, ALUOp, halted};

  typedef struct {
    logic [5:0]  op;
    logic        z;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [20:0] e(input logic [2:0] st, input logic pcw, input logic ims,
                                    input logic irw, input logic [1:0] ext,
                                    input logic [1:0] rout, input logic rw, input logic asb,
                                    input logic m2r, input logic dmw, input logic wrd,
                                    input logic [1:0] pcs, input logic [2:0] aop,
                                    input logic h);
    return {st, pcw, ims, irw, ext, rout, rw, asb, m2r, dmw, wrd, pcs, aop, h};
  endfunction

  function automatic logic [20:0] f_if();
    return e(3'd0, 0, 1, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
  endfunction

  function automatic logic [20:0] f_id();
    return e(3'd1, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0);
  endfunction

  function automatic logic [20:0] f_aexe(input logic [1:0] ext, input logic asb,
                                         input logic [2:0] aop);
    return e(3'd6, 0, 0, 0, ext, 2'd0, 0, asb, 0, 0, 0, 2'd0, aop, 0);
  endfunction

  function automatic logic [20:0] f_awb(input logic [1:0] rout);
    return e(3'd7, 1, 0, 0, 2'd0, rout, 1, 0, 0, 0, 1, 2'd0, 3'd0, 0);
  endfunction

  function automatic logic [20:0] f_pc_only(input logic [1:0] pcs);
    return e(3'd1, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, pcs, 3'd0, 0);
  endfunction

  task automatic row(input logic [5:0] op, input logic z, input logic [20:0] exp);
    vec_t v;
    v.op  = op;
    v.z   = z;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic alu_seq(input logic [5:0] op, input logic [1:0] ext, input logic asb,
                         input logic [2:0] aop, input logic [1:0] rout);
    row(op, 0, f_if());
    row(op, 0, f_id());
    row(op, 0, f_aexe(ext, asb, aop));
    row(op, 0, f_awb(rout));
  endtask

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
    zero   = 1'b0;

    alu_seq(6'b000000, 2'b00, 0, 3'b000, 2'b01);  // add
    alu_seq(6'b000001, 2'b00, 0, 3'b001, 2'b01);  // sub
    alu_seq(6'b100110, 2'b00, 0, 3'b010, 2'b01);  // slt
    alu_seq(6'b010000, 2'b00, 0, 3'b011, 2'b01);  // or
    alu_seq(6'b010001, 2'b00, 0, 3'b100, 2'b01);  // and
    alu_seq(6'b011000, 2'b10, 0, 3'b101, 2'b01);  // sll
    alu_seq(6'b000010, 2'b01, 1, 3'b000, 2'b00);  // addi
    alu_seq(6'b010010, 2'b00, 1, 3'b011, 2'b00);  // ori
    // beq taken then not taken
    row(6'b110100, 1, f_if());
    row(6'b110100, 1, f_id());
    row(6'b110100, 1, e(3'd5, 1, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 2'd1, 3'd1, 0));
    row(6'b110100, 0, f_if());
    row(6'b110100, 0, f_id());
    row(6'b110100, 0, e(3'd5, 1, 0, 0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 2'd0, 3'd1, 0));
    // lw
    row(6'b110001, 0, f_if());
    row(6'b110001, 0, f_id());
    row(6'b110001, 0, e(3'd2, 0, 0, 0, 2'd1, 2'd0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 0));
    row(6'b110001, 0, e(3'd3, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0));
    row(6'b110001, 0, e(3'd4, 1, 0, 0, 2'd0, 2'd0, 1, 0, 1, 0, 1, 2'd0, 3'd0, 0));
    // sw
    row(6'b110000, 0, f_if());
    row(6'b110000, 0, f_id());
    row(6'b110000, 0, e(3'd2, 0, 0, 0, 2'd1, 2'd0, 0, 1, 0, 0, 0, 2'd0, 3'd0, 0));
    row(6'b110000, 0, e(3'd3, 1, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 2'd0, 3'd0, 0));
    // j, undefined opcode
    row(6'b111000, 0, f_if());
    row(6'b111000, 0, f_pc_only(2'b11));
    row(6'b000011, 0, f_if());
    row(6'b000011, 0, f_pc_only(2'b00));
    // jal, jr
    row(6'b111010, 0, f_if());
`ifdef CTRL_JAL_JR_EN
    row(6'b111010, 0, e(3'd1, 1, 0, 0, 2'd0, 2'd2, 1, 0, 0, 0, 0, 2'd3, 3'd0, 0));
`else
    row(6'b111010, 0, f_pc_only(2'b00));
`endif
    row(6'b111001, 0, f_if());
`ifdef CTRL_JAL_JR_EN
    row(6'b111001, 0, f_pc_only(2'b10));
`else
    row(6'b111001, 0, f_pc_only(2'b00));
`endif
    // halt: sID decodes with no enables; halted appears after the edge
    row(6'b111111, 0, f_if());
    row(6'b111111, 0, f_id());

    #12;
    check("reset_state", obs, f_if());
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      zero   = vecs[i].z;
      #2;
      check($sformatf("row%0d_op%b", i, vecs[i].op), obs, vecs[i].exp);
      step();
    end

    // Parked after halt regardless of opcode
    opcode = 6'b000000;
    for (int k = 0; k < 20; k++) begin
      check($sformatf("halt_park%0d", k), obs,
            e(3'd0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 3'd0, 1));
      step();
    end

    rst_n = 1'b0;
    #1;
    check("halt_reset_async", obs, f_if());
    rst_n = 1'b1;
    #1;
    check("halt_cleared", obs, f_if());

    // Reset in the middle of aWB
    step();
    check("mid_id", obs, f_id());
    step();
    step();
    check_bit("awb_regwre_before", RegWre, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("awb_abort", obs, f_if());
    check_bit("awb_abort_regwre", RegWre, 1'b0);
    rst_n = 1'b1;
    #1;
    check("after_abort", obs, f_if());
    step();
    check("restart_id", obs, f_id());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
